// File: rtl/wb_intercon_tmo_if.sv
// Wishbone bus bundle for the CPU-side register interconnect.
// The interconnect reaches the CPU through the 'slave' modport: it is a
// Wishbone slave to the CPU. It reaches the peripherals through the 'master'
// modport: it is a Wishbone master to them.
//   slave  : i_wbm_* requests in, o_wbm_* responses out
//   master : o_wbs_* requests out (cyc/stb one-hot per slave, the rest shared),
//            i_wbs_* responses in (read data flattened, slave k at [k*DATA_W +: DATA_W])
interface wb_intercon_tmo_if #(
  parameter int NUM_SLAVE = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic                        i_wbm_cyc;
  logic                        i_wbm_stb;
  logic                        i_wbm_we;
  logic [DATA_W/8-1:0]         i_wbm_sel;
  logic [ADDR_W-1:0]           i_wbm_addr;
  logic [DATA_W-1:0]           i_wbm_data;
  logic [DATA_W-1:0]           o_wbm_data;
  logic                        o_wbm_ack;
  logic                        o_wbm_err;

  logic [NUM_SLAVE-1:0]        o_wbs_cyc;
  logic [NUM_SLAVE-1:0]        o_wbs_stb;
  logic                        o_wbs_we;
  logic [DATA_W/8-1:0]         o_wbs_sel;
  logic [ADDR_W-1:0]           o_wbs_addr;
  logic [DATA_W-1:0]           o_wbs_data;
  logic [NUM_SLAVE*DATA_W-1:0] i_wbs_data;
  logic [NUM_SLAVE-1:0]        i_wbs_ack;

  modport slave (
    input  i_wbm_cyc, i_wbm_stb, i_wbm_we, i_wbm_sel, i_wbm_addr, i_wbm_data,
    output o_wbm_data, o_wbm_ack, o_wbm_err
  );

  modport master (
    output o_wbs_cyc, o_wbs_stb, o_wbs_we, o_wbs_sel, o_wbs_addr, o_wbs_data,
    input  i_wbs_data, i_wbs_ack
  );
endinterface

// File: rtl/wb_intercon_tmo.sv
// Single-master Wishbone decoder/interconnect with ack timeout.
// The interconnect registers each request. It decodes the slave index from
// addr[SEL_LSB +: SEL_W] and drives a one-hot cyc/stb to the selected slave.
// It returns the slave's ack and read data as a registered one-cycle response.
// It answers an unmapped address or a slave that never acks with a one-cycle
// error, so a dead slave cannot hang the CPU.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   cpu         : CPU-facing Wishbone port (slave modport)
//   per         : peripheral-facing Wishbone port (master modport)
//   o_busy      : high whenever a transfer is in progress
//   o_tmo_cnt   : saturating count of ack timeouts
//   o_err_addr  : address of the most recent unmapped/timeout error
module wb_intercon_tmo #(
  parameter int NUM_SLAVE = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SEL_LSB   = 8,
  parameter int SEL_W     = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wb_intercon_tmo_if.slave      cpu,
  wb_intercon_tmo_if.master     per,
  output logic                  o_busy,
  output logic [15:0]           o_tmo_cnt,
  output logic [ADDR_W-1:0]     o_err_addr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [SEL_W:0] NUM_S = (SEL_W + 1)'(NUM_SLAVE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                state_q, state_d;
  logic [NUM_SLAVE-1:0]  stb_q, stb_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  we_q;
  logic [DATA_W/8-1:0]   sel_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [ADDR_W-1:0]     err_addr_q, err_addr_d;
  logic [15:0]           tmo_cnt_q;

  logic                  load_req;
  logic                  cap_rd;
  logic                  clr_rd;
  logic                  err_lat;
  logic                  tmo_inc;

  logic [SEL_W-1:0]      req_idx;
  logic                  req_mapped;
  logic [NUM_SLAVE-1:0]  req_dec;
  logic                  sel_ack;
  logic [DATA_W-1:0]     rd_mux;

  assign req_idx    = cpu.i_wbm_addr[SEL_LSB +: SEL_W];
  assign req_mapped = ({1'b0, req_idx} < NUM_S);

  // Only the selected slave's ack counts; stb_q is one-hot while in ACCESS.
  assign sel_ack = |(per.i_wbs_ack & stb_q);

  always_comb begin
    req_dec = '0;
    for (int k = 0; k < NUM_SLAVE; k++) begin
      req_dec[k] = (req_idx == SEL_W'(k));
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_SLAVE; k++) begin
      if (stb_q[k]) rd_mux = per.i_wbs_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stb_d      = stb_q;
    cnt_d      = cnt_q;
    load_req   = 1'b0;
    cap_rd     = 1'b0;
    clr_rd     = 1'b0;
    err_lat    = 1'b0;
    tmo_inc    = 1'b0;
    err_addr_d = addr_q;
    case (state_q)
      IDLE: begin
        if (cpu.i_wbm_cyc && cpu.i_wbm_stb) begin
          load_req = 1'b1;
          cnt_d    = '0;
          if (req_mapped) begin
            state_d = ACCESS;
            stb_d   = req_dec;
          end else begin
            state_d    = ERR;
            err_lat    = 1'b1;
            clr_rd     = 1'b1;
            err_addr_d = cpu.i_wbm_addr;
          end
        end
      end
      ACCESS: begin
        // A master abort outranks both ack and expiry: nothing is reported.
        if (!cpu.i_wbm_cyc) begin
          state_d = IDLE;
          stb_d   = '0;
        end else if (sel_ack) begin
          state_d = RESP;
          stb_d   = '0;
          cap_rd  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
          stb_d   = '0;
          tmo_inc = 1'b1;
          err_lat = 1'b1;
          clr_rd  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request/response registers; cleared by reset so a dropped transfer leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_addr_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      if (load_req) begin
        we_q    <= cpu.i_wbm_we;
        sel_q   <= cpu.i_wbm_sel;
        addr_q  <= cpu.i_wbm_addr;
        wdata_q <= cpu.i_wbm_data;
      end
      // Read data is captured on writes as well; error responses return zero.
      if (cap_rd) begin
        rdata_q <= rd_mux;
      end else if (clr_rd) begin
        rdata_q <= '0;
      end
      if (err_lat) err_addr_q <= err_addr_d;
      if (tmo_inc) tmo_cnt_q <= sat_inc16(tmo_cnt_q);
    end
  end

  assign per.o_wbs_cyc  = stb_q;
  assign per.o_wbs_stb  = stb_q;
  assign per.o_wbs_we   = we_q;
  assign per.o_wbs_sel  = sel_q;
  assign per.o_wbs_addr = addr_q;
  assign per.o_wbs_data = wdata_q;

  assign cpu.o_wbm_data = rdata_q;
  assign cpu.o_wbm_ack  = (state_q == RESP);
  assign cpu.o_wbm_err  = (state_q == ERR);

  assign o_busy     = (state_q != IDLE);
  assign o_tmo_cnt  = tmo_cnt_q;
  assign o_err_addr = err_addr_q;

endmodule

// File: tb/tb_wb_intercon_tmo.sv
module tb_wb_intercon_tmo;
  localparam int NS = 3;

  logic clk;
  logic rst_n;
  logic        busy;
  logic [15:0] tmo_cnt;
  logic [31:0] err_addr;

  wb_intercon_tmo_if #(.NUM_SLAVE(NS), .ADDR_W(32), .DATA_W(32)) bus ();

  wb_intercon_tmo #(
    .NUM_SLAVE(NS), .ADDR_W(32), .DATA_W(32),
    .SEL_LSB(8), .SEL_W(4), .TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu        (bus),
    .per        (bus),
    .o_busy     (busy),
    .o_tmo_cnt  (tmo_cnt),
    .o_err_addr (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave models: ack_delay[k]=n acks in the n-th strobe cycle (0 = never).
  int          ack_delay [NS];
  logic [31:0] rd_data   [NS];
  int          stb_cnt   [NS];
  logic [NS-1:0] force_ack;

  always @(posedge clk) begin
    for (int k = 0; k < NS; k++) stb_cnt[k] <= bus.o_wbs_stb[k] ? stb_cnt[k] + 1 : 0;
  end

  always_comb begin
    bus.i_wbs_ack  = force_ack;
    bus.i_wbs_data = '0;
    for (int k = 0; k < NS; k++) begin
      bus.i_wbs_data[k*32 +: 32] = rd_data[k];
      if (bus.o_wbs_stb[k] && ack_delay[k] != 0 && stb_cnt[k] + 1 == ack_delay[k])
        bus.i_wbs_ack[k] = 1'b1;
    end
  end

  // Scoreboard of expected responses.
  typedef struct { bit is_err; logic [31:0] data; } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_wbs_stb != '0) check("stb_onehot", 64'($countones(bus.o_wbs_stb)), 64'd1);
      if (bus.o_wbm_ack || bus.o_wbm_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 64'(exp_q.size()), 64'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("resp_kind", {62'd0, bus.o_wbm_ack, bus.o_wbm_err}, e.is_err ? 64'd1 : 64'd2);
          check("resp_data", 64'(bus.o_wbm_data), 64'(e.data));
        end
      end
    end
  end

  int          stb_cycles, lat;
  logic [NS-1:0] stb_seen;
  logic [31:0] wbs_data_seen, wbs_addr_seen;
  logic        wbs_we_seen;

  task automatic run_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input bit exp_err, input logic [31:0] exp_data);
    exp_t e;
    bit done;
    e.is_err = exp_err;
    e.data   = exp_data;
    @(negedge clk);
    exp_q.push_back(e);
    bus.i_wbm_cyc  = 1'b1;
    bus.i_wbm_stb  = 1'b1;
    bus.i_wbm_we   = we;
    bus.i_wbm_sel  = 4'hF;
    bus.i_wbm_addr = addr;
    bus.i_wbm_data = wdata;
    stb_cycles = 0; lat = 0; stb_seen = '0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (bus.o_wbs_stb != '0) begin
        stb_cycles++;
        stb_seen      = stb_seen | bus.o_wbs_stb;
        wbs_data_seen = bus.o_wbs_data;
        wbs_addr_seen = bus.o_wbs_addr;
        wbs_we_seen   = bus.o_wbs_we;
      end
      if (bus.o_wbm_ack || bus.o_wbm_err) done = 1;
    end
    bus.i_wbm_cyc = 1'b0;
    bus.i_wbm_stb = 1'b0;
    check("xfer_done", 64'(done), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_wbm_cyc = 0; bus.i_wbm_stb = 0; bus.i_wbm_we = 0;
    bus.i_wbm_sel = '0; bus.i_wbm_addr = '0; bus.i_wbm_data = '0;
    force_ack = '0;
    for (int k = 0; k < NS; k++) begin ack_delay[k] = 0; rd_data[k] = '0; end

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stb", 64'(bus.o_wbs_stb), 64'd0);
    check("rst_ack_err", {62'd0, bus.o_wbm_ack, bus.o_wbm_err}, 64'd0);
    check("rst_tmo", 64'(tmo_cnt), 64'd0);
    check("rst_err_addr", 64'(err_addr), 64'd0);
    rst_n = 1'b1;

    // Write to slave 1, acked in its 2nd strobe cycle.
    ack_delay[1] = 2; rd_data[1] = 32'hA5A5_0001;
    run_xfer(32'h0000_0104, 1'b1, 32'hDEAD_BEEF, 0, 32'hA5A5_0001);
    check("wr_stb_sel", 64'(stb_seen), 64'b010);
    check("wr_stb_cycles", 64'(stb_cycles), 64'd2);
    check("wr_latency", 64'(lat), 64'd3);
    check("wr_wbs_data", 64'(wbs_data_seen), 64'hDEAD_BEEF);
    check("wr_wbs_addr", 64'(wbs_addr_seen), 64'h0000_0104);
    check("wr_wbs_we", 64'(wbs_we_seen), 64'd1);

    // Read from slave 2 with a combinational ack.
    ack_delay[2] = 1; rd_data[2] = 32'h1234_5678;
    run_xfer(32'h0000_0200, 1'b0, 32'h0, 0, 32'h1234_5678);
    check("rd_stb_sel", 64'(stb_seen), 64'b100);
    check("rd_stb_cycles", 64'(stb_cycles), 64'd1);
    check("rd_latency", 64'(lat), 64'd2);
    check("rd_wbs_we", 64'(wbs_we_seen), 64'd0);

    // Unmapped index 5.
    run_xfer(32'h0000_0500, 1'b0, 32'h0, 1, 32'h0);
    check("unm_no_stb", 64'(stb_cycles), 64'd0);
    check("unm_latency", 64'(lat), 64'd1);
    check("unm_err_addr", 64'(err_addr), 64'h0000_0500);
    check("unm_tmo", 64'(tmo_cnt), 64'd0);

    // Slave 0 never acks: timeout after 16 strobe cycles.
    ack_delay[0] = 0; rd_data[0] = 32'h0BAD_0000;
    run_xfer(32'h0000_0010, 1'b0, 32'h0, 1, 32'h0);
    check("tmo_stb_cycles", 64'(stb_cycles), 64'd16);
    check("tmo_latency", 64'(lat), 64'd17);
    check("tmo_cnt1", 64'(tmo_cnt), 64'd1);
    check("tmo_err_addr", 64'(err_addr), 64'h0000_0010);

    // Ack in the expiry cycle wins.
    ack_delay[0] = 16;
    run_xfer(32'h0000_0014, 1'b0, 32'h0, 0, 32'h0BAD_0000);
    check("late_stb_cycles", 64'(stb_cycles), 64'd16);
    check("late_latency", 64'(lat), 64'd17);
    check("late_tmo", 64'(tmo_cnt), 64'd1);
    check("late_err_addr", 64'(err_addr), 64'h0000_0010);

    // Master abort in the 3rd ACCESS cycle, then a stray ack.
    ack_delay[0] = 4;
    @(negedge clk);
    bus.i_wbm_cyc = 1'b1; bus.i_wbm_stb = 1'b1; bus.i_wbm_we = 1'b0; bus.i_wbm_addr = 32'h0000_0020;
    @(negedge clk);
    check("abort_stb_c1", 64'(bus.o_wbs_stb), 64'b001);
    @(negedge clk);
    @(negedge clk);
    bus.i_wbm_cyc = 1'b0; bus.i_wbm_stb = 1'b0;
    @(negedge clk);
    check("abort_stb_clr", 64'(bus.o_wbs_stb), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    force_ack[0] = 1'b1;
    @(negedge clk);
    force_ack[0] = 1'b0;
    check("abort_idle", 64'(busy), 64'd0);
    @(negedge clk);
    check("abort_no_resp", 64'(exp_q.size()), 64'd0);

    // Reset asserted mid-ACCESS.
    ack_delay[0] = 0;
    @(negedge clk);
    bus.i_wbm_cyc = 1'b1; bus.i_wbm_stb = 1'b1; bus.i_wbm_addr = 32'h0000_0030;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    bus.i_wbm_cyc = 1'b0; bus.i_wbm_stb = 1'b0;
    #1;
    check("mrst_stb", 64'(bus.o_wbs_stb), 64'd0);
    check("mrst_cyc", 64'(bus.o_wbs_cyc), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_tmo", 64'(tmo_cnt), 64'd0);
    check("mrst_err_addr", 64'(err_addr), 64'd0);
    check("mrst_rdata", 64'(bus.o_wbm_data), 64'd0);
    check("mrst_wbs_addr", 64'(bus.o_wbs_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    ack_delay[2] = 1; rd_data[2] = 32'hCAFE_F00D;
    run_xfer(32'h0000_0204, 1'b0, 32'h0, 0, 32'hCAFE_F00D);
    check("post_rst_stb", 64'(stb_seen), 64'b100);
    check("post_rst_latency", 64'(lat), 64'd2);

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_intercon_tmo.md
# wb_intercon_tmo

Parametrised single-master Wishbone decoder/interconnect for the CPU-side register bus between the soc core and the peripheral slaves (ptp, ptp_gen, tss). It generalises the fixed three-slave interconnect to NUM_SLAVE slaves with address-field decoding. It adds three things: a registered request path, an error response for unmapped addresses, and a per-transaction ack timeout with diagnostic counters. This keeps a dead or unclocked slave from hanging the CPU.

## Interface
- NUM_SLAVE, 3, number of slave ports (1..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- SEL_LSB, 8, lowest address bit of the slave-index field
- SEL_W, 4, slave-index field width; must satisfy 2^SEL_W >= NUM_SLAVE
- TIMEOUT, 255, cycles a slave strobe stays asserted without ack before abort (>=2)
- clk  in  1  bus clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- i_wbm_cyc, i_wbm_stb, i_wbm_we  in  1 each  master cycle/strobe/write
- i_wbm_sel  in  DATA_W/8  byte selects
- i_wbm_addr  in  ADDR_W  address
- i_wbm_data  in  DATA_W  write data
- o_wbm_data  out  DATA_W  read data, registered
- o_wbm_ack  out  1  one-cycle ack pulse
- o_wbm_err  out  1  one-cycle error pulse (unmapped or timeout)
- o_wbs_cyc, o_wbs_stb  out  NUM_SLAVE each  one-hot per-slave cycle/strobe
- o_wbs_we  out  1  shared write enable (ANDed with selected strobe by slaves)
- o_wbs_sel  out  DATA_W/8  shared byte selects
- o_wbs_addr  out  ADDR_W  shared address
- o_wbs_data  out  DATA_W  shared write data
- i_wbs_data  in  NUM_SLAVE*DATA_W  flattened read data, slave k at [k*DATA_W +: DATA_W]
- i_wbs_ack  in  NUM_SLAVE  per-slave ack
- o_busy  out  1  high whenever state != IDLE
- o_tmo_cnt  out  16  saturating count of timeouts
- o_err_addr  out  ADDR_W  address of the most recent error (unmapped or timeout)

## Operation
- States: IDLE, ACCESS, RESP, ERR.
- IDLE: on i_wbm_cyc & i_wbm_stb, latch addr/we/sel/data into the shared o_wbs_* registers. Compute idx = i_wbm_addr[SEL_LSB +: SEL_W].
  - If idx < NUM_SLAVE: go to ACCESS and set o_wbs_cyc[idx] and o_wbs_stb[idx].
  - Otherwise: latch o_err_addr and go to ERR.
- ACCESS: selected strobe held; shared outputs stable.
  - i_wbs_ack[idx]=1: capture i_wbs_data slice idx into o_wbm_data, clear the slave strobes, go to RESP.
  - Acks from non-selected slaves are ignored.
  - Timeout counter starts at 0 on entry and increments each ACCESS cycle without ack. At counter == TIMEOUT-1 with no ack: clear strobes, o_tmo_cnt += 1 (saturating at 0xFFFF), latch o_err_addr, go to ERR.
  - Ack in the expiry cycle wins: go to RESP with no timeout recorded.
  - i_wbm_cyc low: clear strobes next edge and go to IDLE. No ack or err is issued, and a late slave ack is ignored.
- RESP: o_wbm_ack=1 for one cycle, then IDLE. On writes, o_wbm_data still updates from the slave bus.
- ERR: o_wbm_err=1 for one cycle, o_wbm_data=0, then IDLE.
- o_wbm_ack and o_wbm_err are never high together. At most one o_wbs_stb bit is high.
- Reset (async, any state): state=IDLE; all outputs 0, including o_tmo_cnt, o_err_addr and o_wbm_data. A transfer in flight is dropped silently.

## Timing
- Request sampled at edge E0. Selected slave strobe is high from the cycle after E0.
- Slave ack seen at edge En. o_wbm_ack is high in the cycle after En.
- Minimum stb-to-ack is 2 cycles (a combinational-ack slave acks in the first strobe cycle).
- Unmapped address: o_wbm_err high in the cycle after E0.
- Timeout: slave strobe high for exactly TIMEOUT cycles, then o_wbm_err for one cycle.
- Back-to-back: a new request is sampled in the IDLE cycle following RESP/ERR, so the minimum period is 3 cycles per transfer. The master must drop stb after ack/err, or present a new request.

## Test plan
- NUM_SLAVE=3, SEL_LSB=8: write 0xDEADBEEF to 0x0000_0104, slave 1 acks in its 2nd strobe cycle.
  - Required: o_wbs_stb=3'b010 for 2 cycles, o_wbs_data=0xDEADBEEF, one o_wbm_ack pulse 1 cycle after the slave ack, o_wbm_err=0.
- Read 0x0000_0200, slave 2 returns 0x12345678 with a combinational ack.
  - Required: o_wbm_data=0x12345678 together with o_wbm_ack, 2 cycles after stb.
- Access 0x0000_0500 (idx 5).
  - Required: no slave strobe, o_wbm_err pulse 1 cycle after the request, o_err_addr=0x500, o_tmo_cnt unchanged.
- TIMEOUT=16, slave 0 never acks.
  - Required: o_wbs_stb[0] high exactly 16 cycles, then o_wbm_err; o_tmo_cnt=1.
  - Repeat with the ack arriving in cycle 16: o_wbm_ack, o_tmo_cnt stays 1.
- Master drops cyc in the 3rd ACCESS cycle, then slave ack arrives 1 cycle later.
  - Required: strobes clear next edge, no ack or err, o_busy=0 after 1 cycle.
- Assert rst_n low mid-ACCESS.
  - Required: all outputs 0 immediately, o_tmo_cnt=0; a subsequent normal read completes correctly.
